// File: rtl/pkt_deframer.sv
// Serial-to-parallel packet deframer: hunts for a sync field in a shift window and
// hands aligned packets over with valid/ack. Define SYNC_TOL_EN for 1-bit sync tolerance.
module pkt_deframer #(
  parameter int                PKT_W    = 64,
  parameter int                SYNC_W   = 8,
  parameter int                SYNC_LSB = 38,
  parameter logic [SYNC_W-1:0] SYNC_PAT = {SYNC_W{1'b1}},
  parameter int                CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             en,
  input  logic             pkt_rst,
  input  logic             pkt_ack,
  output logic [PKT_W-1:0] pkt_data,
  output logic             pkt_valid,
  output logic             ovf,
  output logic [CNT_W-1:0] pkt_cnt
);

  localparam int BC_W = $clog2(PKT_W + 1);

  typedef enum logic {FILL, ARMED} state_t;

  state_t           state_q;
  // The window MSB is never needed after a shift, so only PKT_W-1 bits are stored.
  logic [PKT_W-2:0] sreg_q;
  logic [PKT_W-1:0] sreg_d;
  logic [BC_W-1:0]  bcnt_q;
  logic [BC_W-1:0]  bcnt_d;
  logic [PKT_W-1:0] data_q;
  logic             valid_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sync_ok;
  logic             match;
  logic             take;

  always_comb begin
    sreg_d = {sreg_q, din};
    bcnt_d = (bcnt_q == BC_W'(PKT_W)) ? bcnt_q : bcnt_q + BC_W'(1);
  end

`ifdef SYNC_TOL_EN
  localparam int PC_W = $clog2(SYNC_W + 1);

  logic [SYNC_W-1:0] diff;
  logic [PC_W-1:0]   ones;

  always_comb begin
    diff = sreg_d[SYNC_LSB +: SYNC_W] ^ SYNC_PAT;
    ones = '0;
    for (int i = 0; i < SYNC_W; i++) begin
      ones = ones + PC_W'(diff[i]);
    end
    sync_ok = (ones <= PC_W'(1));
  end
`else
  always_comb begin
    sync_ok = (sreg_d[SYNC_LSB +: SYNC_W] == SYNC_PAT);
  end
`endif

  always_comb begin
    match = en && !pkt_rst && (state_q == ARMED) && sync_ok;
    take  = !valid_q || pkt_ack;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= FILL;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (pkt_rst) begin
      state_q <= FILL;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      ovf_q   <= 1'b0;
      if (pkt_ack) begin
        valid_q <= 1'b0;
      end
    end else if (match) begin
      // A matched window is consumed whether it is captured or dropped.
      state_q <= FILL;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      if (take) begin
        data_q  <= sreg_d;
        valid_q <= 1'b1;
        cnt_q   <= cnt_q + CNT_W'(1);
      end else begin
        ovf_q <= 1'b1;
      end
    end else begin
      if (pkt_ack) begin
        valid_q <= 1'b0;
      end
      if (en) begin
        sreg_q  <= sreg_d[PKT_W-2:0];
        bcnt_q  <= bcnt_d;
        state_q <= (bcnt_d >= BC_W'(PKT_W - 1)) ? ARMED : FILL;
      end
    end
  end

  assign pkt_data  = data_q;
  assign pkt_valid = valid_q;
  assign ovf       = ovf_q;
  assign pkt_cnt   = cnt_q;

endmodule
